// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared encodings for the unified memory arbiter
package unified_mem_arbiter_pkg;

   localparam int CPU_ADDR_W = 16;
   localparam int CPU_DATA_W = 16;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY_I  = 2'd1;
   localparam logic [1:0] BUSY_D  = 2'd2;
   localparam logic [1:0] DRAIN_I = 2'd3;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - watchdog counter flagging the last permitted wait cycle
module arb_timeout_counter #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - serialises IF fetches and MEM loads/stores onto one memory port
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = CPU_ADDR_W,
   parameter int DATA_W     = CPU_DATA_W,
   parameter int TIMEOUT    = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_err
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [1:0]        state_q, state_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_err_q, mem_err_d;

   logic busy, tc, timeout, force_i, grant_d, grant_i, owner;

   assign busy    = (state_q != IDLE);
   assign timeout = busy && tc && !mem_ack;
   // A fetch starved for STARVE_MAX data grants overtakes the next data request.
   assign force_i = if_req && !if_flush && (starve_q == STARVE_LIM);
   assign grant_d = (state_q == IDLE) && d_req && !force_i;
   assign grant_i = (state_q == IDLE) && !grant_d && if_req && !if_flush;
   assign owner   = grant_d ? OWN_D : OWN_I;

   arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (grant_d || grant_i),
      .en_i  (busy && !mem_ack),
      .tc_o  (tc)
   );

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_d || grant_i) begin
               mem_req_d  = 1'b1;
               mem_addr_d = (owner == OWN_D) ? d_addr : if_addr;
               mem_we_d   = (owner == OWN_D) ? d_we : 1'b0;
            end
            if (grant_d) begin
               state_d     = BUSY_D;
               mem_wdata_d = d_wdata;
               if (!if_req)
                  starve_d = '0;
               else if (starve_q != STARVE_LIM)
                  starve_d = starve_q + SW'(1);
            end else if (grant_i) begin
               state_d  = BUSY_I;
               starve_d = '0;
            end
         end
         BUSY_I: begin
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end else if (if_flush) begin
               state_d = DRAIN_I;
            end
         end
         default: begin
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
      endcase
      if (timeout) begin
         state_d   = IDLE;
         mem_req_d = 1'b0;
         mem_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign d_valid   = rst_n && (state_q == BUSY_D) && mem_ack;
   assign if_valid  = rst_n && (state_q == BUSY_I) && mem_ack && !if_flush;
   assign d_rdata   = d_valid ? mem_rdata : '0;
   assign if_rdata  = if_valid ? mem_rdata : '0;
   assign stall_if  = rst_n && if_req && !if_valid;
   assign stall_mem = rst_n && d_req && !d_valid;

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
   logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
   logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_valid, d_valid, stall_if, stall_mem, mem_req, mem_we, mem_err;

   int n_checks = 0;
   int n_fail   = 0;

   unified_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(64), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1;
      cyc(); cyc();
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
      n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
      n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
      n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL reset_stall_mem: got %b expected 0", stall_mem); end
      n_checks++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL reset_stall_if: got %b expected 0", stall_if); end
      if_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dut.state_q); end
   endtask

   task automatic test_single_fetch();
      @(negedge clk);
      if_req = 1'b1; if_addr = 16'h0040;
      #1;
      n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_req: got %b expected 1", stall_if); end
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_latency: got %b expected 0", mem_req); end
      for (int c = 0; c < 3; c++) begin
         cyc();
         n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || mem_we !== 1'b0)
            begin n_fail++; $display("FAIL fetch_issue[%0d]: got req=%b addr=%h we=%b expected 1/0040/0", c, mem_req, mem_addr, mem_we); end
         n_checks++; if (stall_if !== 1'b1 || if_valid !== 1'b0)
            begin n_fail++; $display("FAIL fetch_wait[%0d]: got stall=%b valid=%b expected 1/0", c, stall_if, if_valid); end
      end
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 16'hA5A5;
      #1;
      n_checks++; if (if_valid !== 1'b1 || if_rdata !== 16'hA5A5 || stall_if !== 1'b0)
         begin n_fail++; $display("FAIL fetch_done: got valid=%b data=%h stall=%b expected 1/a5a5/0", if_valid, if_rdata, stall_if); end
      @(negedge clk);
      mem_ack = 1'b0; if_req = 1'b0;
      #1;
      n_checks++; if (if_valid !== 1'b0 || mem_req !== 1'b0)
         begin n_fail++; $display("FAIL fetch_one_cycle: got valid=%b req=%b expected 0/0", if_valid, mem_req); end
   endtask

   task automatic test_priority();
      @(negedge clk);
      if_req = 1'b1; if_addr = 16'h0100;
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h8000; d_wdata = 16'h1234;
      cyc();
      n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h8000 || mem_wdata !== 16'h1234)
         begin n_fail++; $display("FAIL prio_data_first: got req=%b we=%b addr=%h wd=%h expected 1/1/8000/1234", mem_req, mem_we, mem_addr, mem_wdata); end
      mem_ack = 1'b1;
      #1;
      n_checks++; if (d_valid !== 1'b1 || if_valid !== 1'b0)
         begin n_fail++; $display("FAIL prio_store_valid: got d=%b i=%b expected 1/0", d_valid, if_valid); end
      @(negedge clk);
      mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL prio_idle_gap: got %b expected 0", mem_req); end
      cyc();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100 || mem_we !== 1'b0)
         begin n_fail++; $display("FAIL prio_fetch_after: got req=%b addr=%h we=%b expected 1/0100/0", mem_req, mem_addr, mem_we); end
      mem_ack = 1'b1; mem_rdata = 16'h1111;
      #1;
      n_checks++; if (if_valid !== 1'b1 || if_rdata !== 16'h1111)
         begin n_fail++; $display("FAIL prio_fetch_done: got valid=%b data=%h expected 1/1111", if_valid, if_rdata); end
      @(negedge clk);
      mem_ack = 1'b0; if_req = 1'b0;
   endtask

   task automatic test_starvation();
      logic [15:0] a;
      @(negedge clk);
      if_req = 1'b1; if_addr = 16'h0200;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h2000;
      for (int g = 0; g < 4; g++) begin
         a = 16'h2000 + 16'(g);
         cyc();
         n_checks++; if (mem_req !== 1'b1 || mem_addr !== a)
            begin n_fail++; $display("FAIL starve_data[%0d]: got req=%b addr=%h expected 1/%h", g, mem_req, mem_addr, a); end
         mem_ack = 1'b1; mem_rdata = 16'h3000 + 16'(g);
         #1;
         @(negedge clk);
         mem_ack = 1'b0; d_addr = a + 16'h1;
      end
      cyc();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200 || mem_we !== 1'b0)
         begin n_fail++; $display("FAIL starve_forced_fetch: got req=%b addr=%h we=%b expected 1/0200/0", mem_req, mem_addr, mem_we); end
      n_checks++; if (dut.starve_q !== 3'd0) begin n_fail++; $display("FAIL starve_cleared: got %0d expected 0", dut.starve_q); end
      mem_ack = 1'b1; mem_rdata = 16'h7777;
      #1;
      n_checks++; if (if_valid !== 1'b1 || if_rdata !== 16'h7777)
         begin n_fail++; $display("FAIL starve_fetch_done: got valid=%b data=%h expected 1/7777", if_valid, if_rdata); end
      @(negedge clk);
      mem_ack = 1'b0; if_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_flush();
      @(negedge clk);
      if_req = 1'b1; if_addr = 16'h0300;
      cyc();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0300)
         begin n_fail++; $display("FAIL flush_issue: got req=%b addr=%h expected 1/0300", mem_req, mem_addr); end
      @(negedge clk);
      if_flush = 1'b1; if_addr = 16'h0400;
      #1;
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_valid: got %b expected 0", if_valid); end
      @(negedge clk);
      if_flush = 1'b0;
      #1;
      n_checks++; if (dut.state_q !== 2'd3 || mem_req !== 1'b1)
         begin n_fail++; $display("FAIL flush_drain: got state=%0d req=%b expected 3/1", dut.state_q, mem_req); end
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      #1;
      n_checks++; if (if_valid !== 1'b0 || if_rdata !== 16'h0000)
         begin n_fail++; $display("FAIL flush_discard: got valid=%b data=%h expected 0/0000", if_valid, if_rdata); end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      n_checks++; if (dut.state_q !== 2'd0 || mem_req !== 1'b0)
         begin n_fail++; $display("FAIL flush_idle: got state=%0d req=%b expected 0/0", dut.state_q, mem_req); end
      cyc();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0400)
         begin n_fail++; $display("FAIL flush_refetch: got req=%b addr=%h expected 1/0400", mem_req, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 16'h5555;
      #1;
      n_checks++; if (if_valid !== 1'b1 || if_rdata !== 16'h5555)
         begin n_fail++; $display("FAIL flush_refetch_done: got valid=%b data=%h expected 1/5555", if_valid, if_rdata); end
      @(negedge clk);
      mem_ack = 1'b0; if_req = 1'b0;
   endtask

   task automatic test_timeout();
      int pulses = 0, err_at = -1, dv_seen = 0;
      logic req_at_err = 1'b1;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h9000;
      cyc();
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL to_issue: got %b expected 1", mem_req); end
      for (int k = 1; k <= 70; k++) begin
         cyc();
         if (d_valid) dv_seen++;
         if (mem_err) begin
            pulses++;
            if (err_at < 0) begin err_at = k; req_at_err = mem_req; end
            d_req = 1'b0;
         end
      end
      d_req = 1'b0;
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL to_pulses: got %0d expected 1", pulses); end
      n_checks++; if (err_at !== 64) begin n_fail++; $display("FAIL to_cycle: got %0d expected 64", err_at); end
      n_checks++; if (req_at_err !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %b expected 0", req_at_err); end
      n_checks++; if (dv_seen !== 0) begin n_fail++; $display("FAIL to_no_valid: got %0d expected 0", dv_seen); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h7000; d_wdata = 16'hBEEF;
      cyc();
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_issue: got %b expected 1", mem_req); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async: got %b expected 0", mem_req); end
      n_checks++; if (stall_mem !== 1'b0 || d_valid !== 1'b0)
         begin n_fail++; $display("FAIL rst_mid_comb: got stall=%b valid=%b expected 0/0", stall_mem, d_valid); end
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; mem_ack = 1'b1;
      #1;
      n_checks++; if (dut.state_q !== 2'd0 || mem_req !== 1'b0 || d_valid !== 1'b0)
         begin n_fail++; $display("FAIL rst_mid_after: got state=%0d req=%b valid=%b expected 0/0/0", dut.state_q, mem_req, d_valid); end
      cyc();
      n_checks++; if (d_valid !== 1'b0 || mem_req !== 1'b0)
         begin n_fail++; $display("FAIL rst_mid_stray_ack: got valid=%b req=%b expected 0/0", d_valid, mem_req); end
      mem_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_priority();
      test_starvation();
      test_flush();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 16-bit pipeline.
- Serialises the two requesters and issues one memory transaction at a time.
- Generates stall indications that the pipeline control merges with the hazard-detection stalls.
- Handles branch flush of an in-flight fetch, and applies a timeout watchdog to every memory transaction.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 64, cycles a transaction may wait for mem_ack before it is aborted.
- STARVE_MAX, 4, consecutive data grants after which a pending fetch is forced ahead.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held stable until if_valid.
- if_addr  in  ADDR_W  fetch address (PC).
- if_flush  in  1  branch taken; cancels the current fetch.
- if_rdata  out  DATA_W  instruction word; valid only with if_valid.
- if_valid  out  1  fetch complete this cycle.
- d_req  in  1  EX/MEM memread or memwrite; held stable until d_valid.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid only with d_valid.
- d_valid  out  1  data access complete this cycle.
- stall_if  out  1  if_req && !if_valid.
- stall_mem  out  1  d_req && !d_valid.
- mem_req  out  1  registered; held high until mem_ack.
- mem_we  out  1  registered.
- mem_addr  out  ADDR_W  registered.
- mem_wdata  out  DATA_W  registered.
- mem_rdata  in  DATA_W  memory read data.
- mem_ack  in  1  one-cycle completion pulse; earliest in the first cycle mem_req is high.
- mem_err  out  1  one-cycle pulse on timeout.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DRAIN_I.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_err=0, timeout counter=0, starve counter=0. Combinational outputs are 0 while rst_n is low. Reset mid-transaction drops mem_req immediately; the memory must tolerate this.
- Arbitration in IDLE:
  - d_req wins over if_req (older instruction), unless starve_cnt==STARVE_MAX and if_req is high.
  - Grant to D: next state BUSY_D; mem_req<=1, mem_we<=d_we, mem_addr<=d_addr, mem_wdata<=d_wdata; starve_cnt++ if if_req is high, else starve_cnt<=0.
  - Grant to I: next state BUSY_I; mem_we<=0, mem_addr<=if_addr; starve_cnt<=0.
  - if_flush in IDLE: no fetch is issued that cycle.
- Latency: request in cycle N, mem_req high in N+1, valid at the earliest in N+1 (zero-wait memory). Minimum 2 cycles per access.
- BUSY_D:
  - On mem_ack: d_valid=1 and d_rdata=mem_rdata, combinationally in the same cycle; mem_req<=0; state<=IDLE.
  - Stores also return d_valid.
- BUSY_I:
  - On mem_ack with no if_flush: if_valid=1, if_rdata=mem_rdata; state<=IDLE.
  - if_flush without mem_ack: state<=DRAIN_I; the transaction cannot be withdrawn.
  - if_flush in the same cycle as mem_ack: if_valid suppressed; state<=IDLE.
- DRAIN_I: waits for mem_ack and discards the data; if_valid is never asserted; state<=IDLE.
- Back-to-back: IDLE always lasts ≥1 cycle between transactions. No combinational path from mem_ack to mem_req.
- Timeout:
  - Counter clears on each grant and increments each busy cycle without mem_ack.
  - When it reaches TIMEOUT-1 with no ack: mem_err pulses, mem_req<=0, state<=IDLE.
  - The requester's valid is not asserted, so the stall persists until the request is reissued or the core traps on mem_err.
- Request changes: if_req or d_req deasserting mid-transaction does not abort it; the response is dropped silently. Exception: a data request always completes with d_valid.

Decomposition:
- Shared cpu package holds:
  - the state encoding (IDLE, BUSY_I, BUSY_D, DRAIN_I as 2-bit localparams);
  - ADDR_W and DATA_W;
  - the grant-owner encoding (OWN_I, OWN_D).
- One natural sub-module, arb_timeout_counter: clear, enable, terminal-count output, parameter TIMEOUT.
- Remaining FSM and mux logic stays flat.

Test Plan:
- Single fetch, if_addr=0x0040, memory acks 3 cycles after mem_req → mem_addr=0x0040, mem_we=0; if_valid for exactly one cycle with if_rdata=0xA5A5; stall_if high for the prior cycles.
- if_req and d_req (store 0x1234 to 0x8000) raised in the same cycle → data issued first (mem_we=1, mem_wdata=0x1234); fetch issued after one IDLE cycle; d_valid precedes if_valid.
- d_req held continuously with if_req pending → after 4 data grants the fetch is granted; starve_cnt returns to 0.
- if_flush asserted one cycle into a BUSY_I fetch; ack 2 cycles later with 0xDEAD → if_valid stays 0; state returns to IDLE; a new fetch is issued the following cycle.
- mem_ack never returned → mem_err pulses exactly once, TIMEOUT cycles after mem_req rises; mem_req drops; d_valid stays 0.
- rst_n pulsed low during BUSY_D → mem_req=0 asynchronously; after release, state is IDLE and no spurious d_valid occurs.
